sar_search_ctrl: RTL and testbench

- Successive-approximation search controller that drives the B operand of the team's magnitude comparator (`comparator_4bit` or a wider equivalent) and consumes its AgreaterB/AeqB/AlessB flags.
- The unknown value sits on the comparator's A input, external to this block.
- Finds A in at most WIDTH trials plus one verify trial, then reports the result.
- It is the initiator/consumer on the other end of the comparator interface and replaces hand-written stimulus sequences in lab benches.

---
 rtl/sar_pkg.sv | 16 +
 rtl/sar_search_ctrl_settle_timer.sv | 31 +++
 rtl/sar_search_ctrl.sv | 118 +++++++++++
 tb/tb_sar_search_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRIAL  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Width of a counter/index covering n distinct values, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sar_search_ctrl_settle_timer.sv
// Load-and-count-down timer: expired rises SETTLE cycles after a load.
module settle_timer
  import sar_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int unsigned CNT_W = cnt_width(SETTLE + 1);

  logic [CNT_W-1:0] count;

  // Reload on each new guess, otherwise count down and flag the final count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (load) begin
      count   <= CNT_W'(SETTLE);
      expired <= (SETTLE == 0);
    end else if (count != '0) begin
      count   <= count - CNT_W'(1);
      expired <= (count == CNT_W'(1));
    end
  end

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving a magnitude comparator's B input.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int unsigned IDX_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MSB_GUESS = WIDTH'(1) << (WIDTH - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             expired;
  logic             load_c;
  logic             one_hot_c;

  // Flag legality and timer reload whenever a new guess is about to be presented.
  always_comb begin
    one_hot_c = $onehot({cmp_gt, cmp_eq, cmp_lt});
    load_c    = ((state == IDLE) && start) ||
                (((state == TRIAL) || (state == VERIFY)) && expired);
  end

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .expired (expired)
  );

  // Search sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      guess  <= '0;
      result <= '0;
      found  <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      idx    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= TRIAL;
            guess  <= MSB_GUESS;
            idx    <= IDX_W'(WIDTH - 1);
            busy   <= 1'b1;
            found  <= 1'b0;
            err    <= 1'b0;
            result <= '0;
          end
        end
        TRIAL: begin
          if (expired) begin
            if (!one_hot_c) begin
              err   <= 1'b1;
              state <= DONE;
            end else if (cmp_eq) begin
              result <= guess;
              found  <= 1'b1;
              state  <= DONE;
            end else if (cmp_gt) begin
              if (idx != '0) begin
                guess[idx - IDX_W'(1)] <= 1'b1;
                idx                    <= idx - IDX_W'(1);
              end else begin
                // A above the all-ones guess cannot happen with a sane comparator.
                result <= guess;
                err    <= 1'b1;
                state  <= DONE;
              end
            end else begin
              guess[idx] <= 1'b0;
              if (idx != '0) begin
                guess[idx - IDX_W'(1)] <= 1'b1;
                idx                    <= idx - IDX_W'(1);
              end else begin
                state <= VERIFY;
              end
            end
          end
        end
        VERIFY: begin
          if (expired) begin
            result <= guess;
            if (one_hot_c && cmp_eq) found <= 1'b1;
            else                     err   <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench: table vectors, random targets vs. a binary-search model, fault sequences.
`timescale 1ns/1ps
module tb_sar_search_ctrl;

  typedef struct {
    bit              s;      // 0: SETTLE=0 instance, 1: SETTLE=2 instance
    logic [3:0]      tgt;
    bit              poke;   // pulse start mid-search
    bit              gap;    // idle after done and check held outputs
    logic [3:0]      res;
    bit              fnd;
    bit              er;
    int              lat;
    int              n;
    logic [4:0][3:0] seq;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start2 = 1'b0;
  logic [3:0] tgt0 = '0, tgt2 = '0;
  logic fault = 1'b0;
  logic sel = 1'b0;

  logic [3:0] guess0, result0, guess2, result2;
  logic busy0, done0, found0, err0, busy2, done2, found2, err2;
  logic gt0, eq0, lt0, gt2, eq2, lt2;

  logic [3:0] guess_c, result_c;
  logic busy_c, done_c, found_c, err_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Behavioural comparators on the A=target, B=guess interface; fault forces gt and lt together.
  assign gt0 = fault ? 1'b1 : (tgt0 > guess0);
  assign eq0 = fault ? 1'b0 : (tgt0 == guess0);
  assign lt0 = fault ? 1'b1 : (tgt0 < guess0);
  assign gt2 = tgt2 > guess2;
  assign eq2 = tgt2 == guess2;
  assign lt2 = tgt2 < guess2;

  sar_search_ctrl #(.WIDTH(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .cmp_gt(gt0), .cmp_eq(eq0), .cmp_lt(lt0),
    .guess(guess0), .busy(busy0), .done(done0),
    .result(result0), .found(found0), .err(err0)
  );

  sar_search_ctrl #(.WIDTH(4), .SETTLE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .cmp_gt(gt2), .cmp_eq(eq2), .cmp_lt(lt2),
    .guess(guess2), .busy(busy2), .done(done2),
    .result(result2), .found(found2), .err(err2)
  );

  always_comb begin
    guess_c  = sel ? guess2  : guess0;
    result_c = sel ? result2 : result0;
    busy_c   = sel ? busy2   : busy0;
    done_c   = sel ? done2   : done0;
    found_c  = sel ? found2  : found0;
    err_c    = sel ? err2    : err0;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start2 = v;
    else   start0 = v;
  endtask

  // Reference: plain binary search over the bits, then one verify trial if no equality.
  function automatic vec_t model(input bit s, input logic [3:0] tgt, input bit gap);
    vec_t       v;
    logic [3:0] acc;
    logic [3:0] trial;
    int         settle;
    settle = s ? 2 : 0;
    v.s = s; v.tgt = tgt; v.poke = 1'b0; v.gap = gap;
    v.seq = '0; v.n = 0; v.fnd = 1'b0; v.er = 1'b0; v.res = '0;
    acc = '0;
    for (int b = 3; b >= 0; b--) begin
      trial = acc | (4'd1 << b);
      v.seq[v.n] = trial;
      v.n++;
      if (tgt == trial) begin
        v.fnd = 1'b1;
        v.res = trial;
        break;
      end
      if (tgt > trial) acc = trial;
    end
    if (!v.fnd) begin
      v.seq[v.n] = acc;
      v.n++;
      v.res = acc;
      v.fnd = (tgt == acc);
      v.er  = !v.fnd;
    end
    v.lat = v.n * (settle + 1) + 1;
    return v;
  endfunction

  function automatic vec_t mk(input bit s, input logic [3:0] tgt, input bit poke, input bit gap,
                              input logic [3:0] res, input int lat, input int n,
                              input logic [4:0][3:0] seq);
    vec_t v;
    v.s = s; v.tgt = tgt; v.poke = poke; v.gap = gap;
    v.res = res; v.fnd = 1'b1; v.er = 1'b0; v.lat = lat; v.n = n; v.seq = seq;
    return v;
  endfunction

  task automatic run_search(input string nm, input vec_t v);
    int              k;
    int              n;
    logic [3:0]      last;
    logic [4:0][3:0] got;
    bit              busy_ok;
    sel = v.s;
    if (v.s) tgt2 = v.tgt;
    else     tgt0 = v.tgt;
    @(negedge clk);
    set_start(v.s, 1'b1);
    @(posedge clk); #1;
    set_start(v.s, 1'b0);
    check({nm, "_start"}, 32'({done_c, busy_c, found_c, err_c, guess_c}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 4'b1000}));
    k = 0; n = 0; last = '0; got = '0; busy_ok = 1'b1;
    while (!done_c && k < 60) begin
      if (busy_c !== 1'b1) busy_ok = 1'b0;
      if (n == 0 || guess_c !== last) begin
        if (n < 5) got[n] = guess_c;
        n++;
        last = guess_c;
      end
      if (v.poke) set_start(v.s, k == 1);
      @(posedge clk); #1;
      k++;
    end
    set_start(v.s, 1'b0);
    check({nm, "_latency"}, 32'(k), 32'(v.lat));
    check({nm, "_busy_during"}, 32'(busy_ok), 32'd1);
    check({nm, "_busy_at_done"}, 32'(busy_c), 32'd0);
    check({nm, "_outcome"}, 32'({result_c, found_c, err_c}), 32'({v.res, v.fnd, v.er}));
    check({nm, "_trials"}, 32'(n), 32'(v.n));
    check({nm, "_guess_seq"}, 32'(got), 32'(v.seq));
    if (v.gap) begin
      repeat (2) begin
        @(posedge clk); #1;
      end
      check({nm, "_held"}, 32'({done_c, busy_c, result_c, found_c, err_c}),
            32'({1'b0, 1'b0, v.res, v.fnd, v.er}));
    end
  endtask

  vec_t tbl[6];
  vec_t rv;
  int   k;
  int   pulses;
  bit   busy_seen;

  initial begin
    tbl[0] = mk(1'b0, 4'b1010, 1'b0, 1'b1, 4'b1010, 4, 3,
                {4'h0, 4'h0, 4'b1010, 4'b1100, 4'b1000});
    tbl[1] = mk(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 6, 5,
                {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000});
    tbl[2] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 4'b1111, 5, 4,
                {4'h0, 4'b1111, 4'b1110, 4'b1100, 4'b1000});
    tbl[3] = mk(1'b1, 4'b0110, 1'b0, 1'b1, 4'b0110, 10, 3,
                {4'h0, 4'h0, 4'b0110, 4'b0100, 4'b1000});
    tbl[4] = mk(1'b0, 4'b1010, 1'b1, 1'b0, 4'b1010, 4, 3,
                {4'h0, 4'h0, 4'b1010, 4'b1100, 4'b1000});
    tbl[5] = mk(1'b0, 4'b0101, 1'b0, 1'b1, 4'b0101, 5, 4,
                {4'h0, 4'b0101, 4'b0110, 4'b0100, 4'b1000});

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    check("reset_s0", 32'({guess0, result0, busy0, done0, found0, err0}), 32'd0);
    check("reset_s2", 32'({guess2, result2, busy2, done2, found2, err2}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_search($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 16; i++) begin
      rv = model(i[0], 4'($urandom_range(0, 15)), 1'b1);
      run_search($sformatf("rand%0d_t%0h", i, rv.tgt), rv);
    end

    // Illegal flags on the second trial.
    sel = 1'b0; tgt0 = 4'b1010;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    @(posedge clk); #1; fault = 1'b1;
    k = 1;
    while (!done0 && k < 20) begin
      @(posedge clk); #1;
      k++;
      fault = 1'b0;
    end
    fault = 1'b0;
    check("fault_latency", 32'(k), 32'd3);
    check("fault_flags", 32'({err0, found0, busy0}), 32'({1'b1, 1'b0, 1'b0}));

    // Restart in the done cycle must clear err.
    rv = model(1'b0, 4'b0011, 1'b1);
    run_search("restart_after_fault", rv);

    // Asynchronous reset mid-search.
    sel = 1'b0; tgt0 = 4'b0000;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midreset_outputs", 32'({guess0, result0, busy0, done0, found0, err0}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0; busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done0) pulses++;
      if (busy0) busy_seen = 1'b1;
    end
    check("midreset_no_done", 32'(pulses), 32'd0);
    check("midreset_idle", 32'(busy_seen), 32'd0);

    rv = model(1'b0, 4'b1001, 1'b1);
    run_search("after_reset", rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
